// File: rtl/diffeq_result_collector.sv
// Frames the diffeq solver's x/y/u outputs into records once they settle, queued in a FWFT FIFO.
// Define DIFFEQ_COLLECT_TIMEOUT_EN to compile in the forced-record timeout path.
//
// state | meaning
// IDLE  | no job in flight
// TRACK | watching the triplet for STABLE_CYCLES unchanged cycles
// PUSH  | one cycle, writing the captured record into the FIFO
module diffeq_result_collector #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024,
  parameter int DEPTH         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] xport,
  input  logic [31:0] yport,
  input  logic [31:0] uport,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_u,
  output logic [31:0] out_sum,
  output logic [15:0] out_cycles,
  output logic        out_timeout,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] STABLE_W = 16'(STABLE_CYCLES);
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 || TIMEOUT > 65535 ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("diffeq_result_collector: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRACK = 2'd1, S_PUSH = 2'd2} state_e;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] u;
    logic [31:0] sum;
    logic [15:0] cycles;
    logic        timeout;
  } rec_t;

  state_e        state_q, state_d;
  logic [95:0]   prev_q;
  logic [15:0]   stable_q, cyc_q;
  rec_t          cap_q;
  rec_t          mem_q [DEPTH];
  rec_t          head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;

  logic [95:0] trip;
  logic [15:0] stable_inc, cyc_inc;
  logic        converge, timeout_hit;
  logic        push, pop, full, push_ok;

  assign trip       = {xport, yport, uport};
  assign stable_inc = (trip == prev_q) ? stable_q + 16'd1 : 16'd0;
  assign cyc_inc    = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
  assign converge   = (state_q == S_TRACK) && (stable_inc == STABLE_W);
`ifdef DIFFEQ_COLLECT_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  assign timeout_hit = (state_q == S_TRACK) && !converge && (cyc_inc == TIMEOUT_W);
`else
  assign timeout_hit = 1'b0;
`endif

  // A start in PUSH abandons the pending record, so it never reaches the FIFO.
  assign push    = (state_q == S_PUSH) && !start;
  assign pop     = out_valid && out_ready;
  assign full    = (count_q == DEPTH_W);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_TRACK: if (converge || timeout_hit) state_d = S_PUSH;
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start) state_d = S_TRACK;
  end

  always_comb begin
    out_valid   = (count_q != '0);
    head        = mem_q[rd_ptr_q];
    out_x       = '0;
    out_y       = '0;
    out_u       = '0;
    out_sum     = '0;
    out_cycles  = '0;
    out_timeout = 1'b0;
    if (out_valid) begin
      out_x       = head.x;
      out_y       = head.y;
      out_u       = head.u;
      out_sum     = head.sum;
      out_cycles  = head.cycles;
      out_timeout = head.timeout;
    end
    busy     = (state_q != S_IDLE);
    overflow = overflow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= '0;
      stable_q <= '0;
      cyc_q    <= '0;
      cap_q    <= '0;
    end else if (start) begin
      prev_q   <= trip;
      stable_q <= '0;
      cyc_q    <= '0;
    end else if (state_q == S_TRACK) begin
      prev_q   <= trip;
      stable_q <= stable_inc;
      cyc_q    <= cyc_inc;
      if (converge || timeout_hit) begin
        cap_q.x       <= xport;
        cap_q.y       <= yport;
        cap_q.u       <= uport;
        cap_q.sum     <= xport + yport + uport;
        cap_q.cycles  <= cyc_inc;
        cap_q.timeout <= !converge;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= cap_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

endmodule
